rx_stream_buf: RTL

- Sample staging buffer directly upstream of the host SPI bridge FIFO, in the hb_clk domain.
- Collects 16-bit receiver words into a circular BRAM buffer.
- On an eCPU burst command, drains the requested number of words as rx_rd/rx_dout write strobes into the bridge FIFO.
- Raises hb_ovfl on sample loss, which the host reports in SPI status; clears it on hb_orst.

---
 rtl/rx_stream_buf.sv | 121 ++++++++++++
 1 files changed

// File: rtl/rx_stream_buf.sv
// rx_stream_buf: circular staging buffer ahead of the host SPI bridge FIFO.
// Buffers receiver words and drains eCPU-requested bursts as write strobes.
module rx_stream_buf #(
  parameter int AW = 11,
  parameter int LW = 12
) (
  input  logic          hb_clk,
  input  logic          hb_rst,
  input  logic          in_valid,
  input  logic [15:0]   in_data,
  input  logic          cmd_go,
  input  logic [LW-1:0] cmd_len,
  input  logic          stall,
  output logic          rx_rd,
  output logic [15:0]   rx_dout,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   avail,
  output logic          hb_ovfl,
  input  logic          hb_orst
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EMIT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [15:0]   mem [2**AW];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   avail_q;
  logic [AW:0]   rem_q;
  logic [AW:0]   rem_len;
  logic [15:0]   dout_q;
  logic          ovfl_q;
  logic          done_q;
  logic          full;
  logic          start;
  logic          pop;
  logic          push;
  logic          last;

  assign full  = avail_q[AW];
  assign start = (state_q == IDLE) && cmd_go && (cmd_len != '0);
  assign pop   = (state_q == FETCH) && (avail_q != '0) && !stall;
  assign push  = in_valid && (!full || pop);
  assign last  = (rem_q == ONE);

  // Oversized requests are clamped to one full buffer.
  assign rem_len = (cmd_len > LW'(DEPTH)) ? DEPTH : cmd_len[AW:0];

  always_ff @(posedge hb_clk) begin
    if (hb_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (pop) state_d = EMIT;
      EMIT:    state_d = last ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_rd = 1'b0;
    busy  = 1'b0;
    unique case (state_q)
      FETCH: busy = 1'b1;
      EMIT: begin
        busy  = 1'b1;
        rx_rd = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge hb_clk) begin
    if (push) mem[wptr_q] <= in_data;
  end

  always_ff @(posedge hb_clk) begin
    if (hb_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      avail_q <= '0;
      rem_q   <= '0;
      dout_q  <= '0;
      ovfl_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
        dout_q <= mem[rptr_q];
      end
      avail_q <= avail_q + (AW+1)'(push) - (AW+1)'(pop);
      if (start) rem_q <= rem_len;
      else if (state_q == EMIT) rem_q <= rem_q - ONE;
      done_q <= (state_q == EMIT) && last;
      // A dropped word outranks a same-cycle host clear.
      if (in_valid && !push) ovfl_q <= 1'b1;
      else if (hb_orst)      ovfl_q <= 1'b0;
    end
  end

  assign rx_dout = dout_q;
  assign done    = done_q;
  assign avail   = avail_q;
  assign hb_ovfl = ovfl_q;

endmodule
